// File: rtl/pkt_pkg.sv
// pkt_pkg: shared constants, FSM state type and last-word byte mask for the packet builder/parser pair.
package pkt_pkg;
  localparam int NUM_STREAMS = 32;
  localparam int STREAM_W = 5;
  localparam int MAX_BYTES = 37;
  localparam int HDR_BYTES = 8;
  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS = 10;
  localparam int MSG_W = MAX_BYTES * 8;
  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_SEQ, SEND_DATA} state_t;
  // rem is bytes%4; zero means the last word is full
  function automatic logic [31:0] last_mask(input logic [1:0] rem);
    logic [5:0] keep;
    keep = (rem == 2'd0) ? 6'd32 : {1'b0, rem, 3'd0};
    return 32'hFFFF_FFFF << (6'd32 - keep);
  endfunction
endpackage

// File: rtl/packet_builder_if.sv
// packet_builder_if: message-in and word-out handshake bundle of the packet builder.
interface packet_builder_if;
  import pkt_pkg::*;
  logic [0:MSG_W-1]    msgIn;
  logic [5:0]          msgIn_bytes;
  logic [STREAM_W-1:0] msgIn_stream;
  logic                msgIn_val;
  logic                msgIn_ready;
  logic [31:0]         dataOut;
  logic                dataOut_val;
  logic                dataOut_ready;
  logic                dataOut_last;
  logic                lenErr;
  modport slave (
    input  msgIn, msgIn_bytes, msgIn_stream, msgIn_val, dataOut_ready,
    output msgIn_ready, dataOut, dataOut_val, dataOut_last, lenErr
  );
  modport master (
    output msgIn, msgIn_bytes, msgIn_stream, msgIn_val, dataOut_ready,
    input  msgIn_ready, dataOut, dataOut_val, dataOut_last, lenErr
  );
endinterface

// File: rtl/seq_table.sv
// seq_table: per-stream 32-bit sequence counters; exposes stored+1 for the addressed stream.
module seq_table
  import pkt_pkg::*;
(
  input  logic                clk,
  input  logic                reset_b,
  input  logic [STREAM_W-1:0] addr_i,
  input  logic                inc_i,
  output logic [31:0]         seq_inc_o
);
  logic [31:0] seq_q [NUM_STREAMS];
  assign seq_inc_o = seq_q[addr_i] + 32'd1;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b)
      for (int i = 0; i < NUM_STREAMS; i++) seq_q[i] <= '0;
    else if (inc_i)
      seq_q[addr_i] <= seq_inc_o;
endmodule

// File: rtl/packet_builder.sv
// packet_builder: serialises one message into header, sequence and payload words with a last flag.
module packet_builder
  import pkt_pkg::*;
(
  input logic             clk,
  input logic             reset_b,
  packet_builder_if.slave bus
);
  state_t           state_q;
  logic [0:MSG_W+23] pay_q;
  logic [5:0]       bytes_q;
  logic [3:0]       idx_q;
  logic [31:0]      seq_q, dout_q;
  logic             val_q, last_q, lenerr_q;
  logic [31:0]      seq_nxt, word_d;
  logic [3:0]       nwords, idx_d;
  logic             legal, accept, take;
  assign legal  = bus.msgIn_bytes != 6'd0 && bus.msgIn_bytes <= 6'(MAX_BYTES);
  assign accept = bus.msgIn_val && state_q == IDLE;
  assign take   = val_q && bus.dataOut_ready;
  assign nwords = 4'((bytes_q + 6'd3) >> 2);
  assign idx_d  = state_q == SEND_DATA ? idx_q + 4'd1 : 4'd0;
  // pay_q is padded to 10 whole words so the last word's slice stays in range
  assign word_d = pay_q[{idx_d, 5'd0} +: 32] & (idx_d == nwords - 4'd1 ? last_mask(bytes_q[1:0]) : '1);
  assign bus.msgIn_ready  = state_q == IDLE;
  assign bus.dataOut      = dout_q;
  assign bus.dataOut_val  = val_q;
  assign bus.dataOut_last = last_q;
  assign bus.lenErr       = lenerr_q;
  seq_table u_seq (
    .clk       (clk),
    .reset_b   (reset_b),
    .addr_i    (bus.msgIn_stream),
    .inc_i     (accept && legal),
    .seq_inc_o (seq_nxt)
  );
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state_q  <= IDLE;
      pay_q    <= '0;
      bytes_q  <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      dout_q   <= '0;
      val_q    <= 1'b0;
      last_q   <= 1'b0;
      lenerr_q <= 1'b0;
    end else begin
      lenerr_q <= accept && !legal;
      case (state_q)
        IDLE: if (accept && legal) begin
          pay_q   <= {bus.msgIn, 24'd0};
          bytes_q <= bus.msgIn_bytes;
          seq_q   <= seq_nxt;
          dout_q  <= {16'(bus.msgIn_bytes) + 16'(HDR_BYTES), 16'(bus.msgIn_stream)};
          val_q   <= 1'b1;
          state_q <= SEND_HDR;
        end
        SEND_HDR: if (take) begin
          dout_q  <= seq_q;
          state_q <= SEND_SEQ;
        end
        SEND_SEQ: if (take) begin
          dout_q  <= word_d;
          last_q  <= nwords == 4'd1;
          idx_q   <= 4'd0;
          state_q <= SEND_DATA;
        end
        SEND_DATA: if (take) begin
          if (last_q) begin
            dout_q  <= '0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            dout_q <= word_d;
            last_q <= idx_d == nwords - 4'd1;
            idx_q  <= idx_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_packet_builder.sv
// tb_packet_builder: directed and random messages checked against a byte-level packet model.
module tb_packet_builder;
  import pkt_pkg::*;
  logic clk = 1'b0;
  logic reset_b;
  int checks = 0;
  int failures = 0;
  int unsigned seqm [NUM_STREAMS];
  packet_builder_if bus ();
  packet_builder dut (.clk(clk), .reset_b(reset_b), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input int n, input logic [7:0] base, input bit rnd, input bit stall);
    logic [7:0] pay [MAX_BYTES];
    logic [31:0] exp [$];
    logic [31:0] w;
    logic [0:MSG_W-1] m;
    int got, budget;
    m = '0;
    for (int k = 0; k < n; k++) begin
      pay[k] = rnd ? 8'($urandom) : base + 8'(k);
      m[8*k +: 8] = pay[k];
    end
    seqm[s] = seqm[s] + 1;
    exp.push_back({16'(n + 8), 16'(s)});
    exp.push_back(seqm[s]);
    for (int wi = 0; wi * 4 < n; wi++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w = {w[23:0], (4*wi + j < n) ? pay[4*wi + j] : 8'h00};
      exp.push_back(w);
    end
    chk("msg_ready_idle", bus.msgIn_ready, 1);
    bus.msgIn = m;
    bus.msgIn_bytes = 6'(n);
    bus.msgIn_stream = 5'(s);
    bus.msgIn_val = 1'b1;
    @(negedge clk);
    bus.msgIn_val = 1'b0;
    got = 0;
    budget = 0;
    while (got < exp.size() && budget < 200) begin
      bus.dataOut_ready = stall ? 1'($urandom % 2) : 1'b1;
      chk("val", bus.dataOut_val, 1);
      chk("word", bus.dataOut, exp[got]);
      chk("last", bus.dataOut_last, 32'(got == exp.size() - 1));
      chk("msg_ready_busy", bus.msgIn_ready, 0);
      if (bus.dataOut_val && bus.dataOut_ready) got++;
      budget++;
      @(negedge clk);
    end
    bus.dataOut_ready = 1'b0;
    chk("timeout_words", got, exp.size());
    chk("val_after", bus.dataOut_val, 0);
    chk("msg_ready_after", bus.msgIn_ready, 1);
  endtask

  task automatic bad(input int n);
    bus.msgIn_bytes = 6'(n);
    bus.msgIn_stream = 5'd3;
    bus.msgIn_val = 1'b1;
    @(negedge clk);
    bus.msgIn_val = 1'b0;
    chk("lenerr_pulse", bus.lenErr, 1);
    chk("lenerr_noval", bus.dataOut_val, 0);
    chk("lenerr_ready", bus.msgIn_ready, 1);
    @(negedge clk);
    chk("lenerr_clear", bus.lenErr, 0);
    chk("lenerr_noval2", bus.dataOut_val, 0);
  endtask

  initial begin
    reset_b = 1'b0;
    bus.msgIn = '0;
    bus.msgIn_bytes = '0;
    bus.msgIn_stream = '0;
    bus.msgIn_val = 1'b0;
    bus.dataOut_ready = 1'b0;
    for (int i = 0; i < NUM_STREAMS; i++) seqm[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_val", bus.dataOut_val, 0);
    chk("rst_last", bus.dataOut_last, 0);
    chk("rst_data", bus.dataOut, 0);
    chk("rst_lenerr", bus.lenErr, 0);
    chk("rst_ready", bus.msgIn_ready, 1);
    reset_b = 1'b1;
    @(negedge clk);
    send(3, 5, 8'hA1, 0, 0);
    send(3, 12, 8'h10, 1, 0);
    send(3, 3, 8'h20, 1, 0);
    send(4, 7, 8'h30, 1, 0);
    send(31, 37, 8'h00, 1, 0);
    send(7, 4, 8'h40, 1, 0);
    send(7, 1, 8'h50, 1, 0);
    send(3, 8, 8'h00, 1, 1);
    send(5, 37, 8'h00, 1, 1);
    bad(0);
    bad(38);
    send(3, 6, 8'h60, 1, 0);
    for (int r = 0; r < 25; r++)
      send(int'($urandom_range(0, NUM_STREAMS - 1)), int'($urandom_range(1, MAX_BYTES)), 8'h00, 1, 1'($urandom % 2));
    bus.msgIn = '1;
    bus.msgIn_bytes = 6'd37;
    bus.msgIn_stream = 5'd3;
    bus.msgIn_val = 1'b1;
    bus.dataOut_ready = 1'b1;
    @(negedge clk);
    bus.msgIn_val = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_val_before", bus.dataOut_val, 1);
    #2 reset_b = 1'b0;
    #1;
    chk("async_val", bus.dataOut_val, 0);
    chk("async_last", bus.dataOut_last, 0);
    chk("async_data", bus.dataOut, 0);
    chk("async_ready", bus.msgIn_ready, 1);
    for (int i = 0; i < NUM_STREAMS; i++) seqm[i] = 0;
    bus.dataOut_ready = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    send(3, 9, 8'h70, 1, 0);
    send(3, 2, 8'h80, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
